// File: rtl/an_decoder_seq_if.sv
// Handshaked bus of the AN decoder: codeword in (valid/ready), decoded N and error flags out (valid/ready).
interface an_decoder_seq_if #(
  parameter int CW = 23,
  parameter int DW = 17,
  parameter int PW = $clog2(CW)
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] ane;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] n_out;
  logic          err_detected;
  logic          err_corrected;
  logic          err_uncorrectable;
  logic [PW-1:0] err_pos;
  logic          err_sign;

  modport master (
    output in_valid, ane, out_ready,
    input  in_ready, out_valid, n_out, err_detected, err_corrected,
           err_uncorrectable, err_pos, err_sign
  );

  modport slave (
    input  in_valid, ane, out_ready,
    output in_ready, out_valid, n_out, err_detected, err_corrected,
           err_uncorrectable, err_pos, err_sign
  );
endinterface

// File: rtl/an_decoder_seq.sv
// Serial AN-code decoder: residue, +/-2^i syndrome search, correction, restoring divide by A.
// Latency 2*CW+s+1 cycles to out_valid; one word in flight, results held in DONE until out_ready.
module an_decoder_seq #(
  parameter int A  = 47,
  parameter int CW = 23,
  parameter int DW = 17,
  parameter int PW = $clog2(CW)
) (
  input  logic           clk,
  input  logic           rst_n,
  an_decoder_seq_if.slave bus
);
  localparam int              RW   = $clog2(A) + 1;
  localparam logic [RW:0]     AX   = (RW+1)'(A);
  localparam logic [PW-1:0]   LAST = PW'(CW - 1);

  typedef enum logic [2:0] {IDLE, RES, SRCH, CORR, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0] word;
  logic [RW-1:0] r, p;
  logic [PW-1:0] cnt, pos_q;
  logic          sign_q, match_q, det_q, cor_q, unc_q;
  logic [DW-1:0] n_q;

  logic          bit_in, r_ge;
  logic [RW:0]   rt, rsub, pd, psub;
  logic [RW-1:0] r_nx, p_nx, neg_p;
  logic          hit_pos, hit_neg;
  logic [CW:0]   one, c_full;
  logic [CW-1:0] q_nx;

  // Shared mod-A step: residue accumulation in RES, partial remainder in DIV.
  always_comb begin
    bit_in  = (state == DIV) ? word[CW-1] : word[cnt];
    rt      = {r, bit_in};
    rsub    = rt - AX;
    r_ge    = (rt >= AX);
    r_nx    = r_ge ? rsub[RW-1:0] : rt[RW-1:0];
    pd      = {p, 1'b0};
    psub    = pd - AX;
    p_nx    = (pd >= AX) ? psub[RW-1:0] : pd[RW-1:0];
    neg_p   = AX[RW-1:0] - p;
    hit_pos = (r == p);
    hit_neg = (r == neg_p);
    one     = {{CW{1'b0}}, 1'b1} << pos_q;
    // Bit CW of the corrected word flags both underflow and overflow.
    if (!match_q)    c_full = {1'b0, word};
    else if (sign_q) c_full = {1'b0, word} + one;
    else             c_full = {1'b0, word} - one;
    q_nx    = {word[CW-2:0], r_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RES;
      end
      RES:  if (cnt == '0) state_nx = SRCH;
      SRCH: begin
        if ((cnt == '0 && r == '0) || hit_pos || hit_neg) state_nx = CORR;
        else if (cnt == LAST)                              state_nx = DONE;
      end
      CORR: state_nx = c_full[CW] ? DONE : DIV;
      DIV:  if (cnt == '0) state_nx = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0; r <= '0; p <= '0; cnt <= '0; pos_q <= '0;
      sign_q <= 1'b0; match_q <= 1'b0; det_q <= 1'b0; cor_q <= 1'b0; unc_q <= 1'b0;
      n_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          word <= bus.ane; r <= '0; cnt <= LAST; pos_q <= '0;
          sign_q <= 1'b0; match_q <= 1'b0; det_q <= 1'b0; cor_q <= 1'b0; unc_q <= 1'b0;
          n_q <= '0;
        end
        RES: begin
          r <= r_nx;
          if (cnt == '0) p <= RW'(1);
          else           cnt <= cnt - PW'(1);
        end
        SRCH: begin
          p     <= p_nx;
          cnt   <= cnt + PW'(1);
          det_q <= (r != '0);
          if (cnt == '0 && r == '0) begin
          end else if (hit_pos) begin
            match_q <= 1'b1; pos_q <= cnt; sign_q <= 1'b0;
          end else if (hit_neg) begin
            match_q <= 1'b1; pos_q <= cnt; sign_q <= 1'b1;
          end else if (cnt == LAST) begin
            unc_q <= 1'b1;
          end
        end
        CORR: begin
          word <= c_full[CW-1:0];
          r    <= '0;
          cnt  <= LAST;
          if (c_full[CW]) unc_q <= 1'b1;
        end
        DIV: begin
          r    <= r_nx;
          word <= q_nx;
          cnt  <= cnt - PW'(1);
          if (cnt == '0) begin
            if (|q_nx[CW-1:DW]) unc_q <= 1'b1;
            else begin
              n_q   <= q_nx[DW-1:0];
              cor_q <= match_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.n_out             = n_q;
  assign bus.err_detected      = det_q;
  assign bus.err_corrected     = cor_q;
  assign bus.err_uncorrectable = unc_q;
  assign bus.err_pos           = pos_q;
  assign bus.err_sign          = sign_q;
endmodule

// File: tb/tb_an_decoder_seq.sv
// Directed-vector bench for the A=47, CW=23 AN decoder: results, flags and latency, plus backpressure and reset corners.
module tb_an_decoder_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  an_decoder_seq_if #(.CW(23), .DW(17), .PW(5)) bus ();
  an_decoder_seq #(.A(47), .CW(23), .DW(17), .PW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [22:0] ane;
    logic [16:0] n;
    logic        det;
    logic        cor;
    logic        unc;
    logic [4:0]  pos;
    logic        sign;
    int          lat;
    bit          rdy_early;
  } vec_t;

  vec_t vecs[$];
  int nvec = 0;
  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.ane       = v.ane;
    bus.out_ready = v.rdy_early;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk($sformatf("v%0d in_ready_busy", idx), 32'(bus.in_ready), 32'd0);
    wait_out(lat);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d n_out", idx), 32'(bus.n_out), 32'(v.n));
    chk($sformatf("v%0d err_detected", idx), 32'(bus.err_detected), 32'(v.det));
    chk($sformatf("v%0d err_corrected", idx), 32'(bus.err_corrected), 32'(v.cor));
    chk($sformatf("v%0d err_uncorrectable", idx), 32'(bus.err_uncorrectable), 32'(v.unc));
    chk($sformatf("v%0d err_pos", idx), 32'(bus.err_pos), 32'(v.pos));
    chk($sformatf("v%0d err_sign", idx), 32'(bus.err_sign), 32'(v.sign));
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_after_hs", idx), 32'(bus.out_valid), 32'd0);
    chk($sformatf("v%0d in_ready_after_hs", idx), 32'(bus.in_ready), 32'd1);
    nvec++;
  endtask

  initial begin
    logic [22:0] clean;
    int lat;
    int seen;
    clean = 23'd57011;
    bus.in_valid  = 1'b0;
    bus.ane       = '0;
    bus.out_ready = 1'b0;

    //                ane       n     det cor unc pos sign lat early
    vecs.push_back('{23'd57011,   17'd1213, 0, 0, 0, 5'd0,  0, 48, 1});
    vecs.push_back('{23'd57015,   17'd1213, 1, 1, 0, 5'd2,  0, 50, 0});
    vecs.push_back('{23'd56979,   17'd1213, 1, 1, 0, 5'd5,  1, 53, 0});
    vecs.push_back('{23'd4251315, 17'd1213, 1, 1, 0, 5'd22, 0, 70, 0});
    vecs.push_back('{23'd57010,   17'd1213, 1, 1, 0, 5'd0,  1, 48, 0});
    vecs.push_back('{23'd24243,   17'd1213, 1, 1, 0, 5'd15, 1, 63, 0});
    vecs.push_back('{23'd3,       17'd0,    1, 0, 1, 5'd19, 0, 44, 0});
    vecs.push_back('{23'd8388607, 17'd0,    0, 0, 1, 5'd0,  0, 48, 0});
    for (int i = 0; i < 23; i++)
      vecs.push_back('{clean ^ (23'd1 << i), 17'd1213, 1'b1, 1'b1, 1'b0,
                       5'(i), clean[i], 48 + i, 1'b0});

    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst n_out", 32'(bus.n_out), 32'd0);
    chk("rst flags", {29'd0, bus.err_detected, bus.err_corrected, bus.err_uncorrectable}, 32'd0);
    chk("rst pos_sign", {26'd0, bus.err_pos, bus.err_sign}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Backpressure: hold DONE for 10 cycles with a competing in_valid.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ane      = 23'd57011;
    @(posedge clk);
    #1 bus.ane = 23'd57015;
    wait_out(lat);
    chk("bp latency", 32'(lat), 32'd48);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp out_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp n_out_hold", 32'(bus.n_out), 32'd1213);
      chk("bp in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp det_hold", 32'(bus.err_detected), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("bp released out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp released in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 chk("bp stays idle", 32'(bus.in_ready), 32'd1);
    nvec++;

    // Reset during DIV aborts the decode silently.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ane      = 23'd56979;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst n_out", 32'(bus.n_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen++;
    end
    chk("mid_rst no_output", 32'(seen), 32'd0);
    nvec++;
    run_vec(vecs[1], 99);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/an_decoder_seq.md
# an_decoder_seq

Parametrised, multi-cycle AN-code decoder with single-bit error correction. It accepts a received AN codeword `ane` (nominally A·N, possibly with one bit flipped) over a valid/ready handshake. It computes the syndrome R = `ane` mod A serially, searches for the matching ±2^i error, corrects the word, and divides by A to recover N. It is the sequential, handshaked successor of the combinational A=47 decoder, and sits between the protected-storage read path and the consumer of N.

## Interface
- `A`, 47: code constant; odd, ≥3.
- `CW`, 23: codeword width.
- `DW`, 17: data (N) width; CW ≥ DW + clog2(A).
- `PW`, $clog2(CW): width of `err_pos`.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock, no other reset.
- `in_valid`  in  1  `ane` valid.
- `in_ready`  out  1  decoder can accept.
- `ane`  in  CW  received codeword.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `n_out`  out  DW  decoded N.
- `err_detected`  out  1  R ≠ 0.
- `err_corrected`  out  1  single-bit error found and corrected.
- `err_uncorrectable`  out  1  no syndrome match, or corrected value out of range.
- `err_pos`  out  PW  corrected bit index i.
- `err_sign`  out  1  0: error was +2^i (R = 2^i mod A); 1: error was −2^i (R = A − (2^i mod A)).

## Operation
- FSM states: IDLE, RES, SRCH, CORR, DIV, DONE.
- IDLE: `in_ready`=1. When `in_valid`&`in_ready` are both high, latch `ane`, clear r, and go to RES.
- RES: CW cycles, MSB first: r ← (2r + bit) mod A. Use a single conditional subtract; keep r in clog2(A)+1 bits.
- SRCH: cycle k tests i=k using p = 2^k mod A, updated incrementally as p ← 2p mod A with p=1 at k=0.
  - Cycle 0 checks R==0 first. If true, there is no error: go to CORR.
  - R==p: sign=0, pos=k. Otherwise R==A−p: sign=1, pos=k. On a match, go to CORR.
  - Lowest k wins; +2^i takes priority over −2^i.
  - If there is no match after k=CW−1, set uncorrectable, set `n_out`=0, and go to DONE.
- CORR, 1 cycle: C = `ane` − 2^pos (sign 0) or `ane` + 2^pos (sign 1). Compute at CW+1 bits.
  - If C < 0 or C ≥ 2^CW, set uncorrectable, set `n_out`=0, and go to DONE. Otherwise go to DIV.
- DIV: CW cycles of restoring division of C by A, MSB first.
  - If the quotient ≥ 2^DW, set uncorrectable and `n_out`=0.
  - Otherwise `n_out` = quotient[DW-1:0].
- DONE: `out_valid`=1. All outputs hold stable until `out_ready`; then go to IDLE.
- `err_corrected`=1 only if a match was found and the result is not uncorrectable.
- `err_pos` and `err_sign` are 0 when there is no match or R=0.

## Timing
- Reset, asynchronous: state=IDLE, `in_ready`=1 while `rst_n`=1, `out_valid`=0, `n_out`=0, and all flags, `err_pos` and `err_sign` are 0.
- Reset mid-operation aborts the decode with no output. The first cycle after release is IDLE.
- Cycle count is measured from the accepting edge to the edge where `out_valid` rises.
  - Decodes that reach DIV: CW + s + 1 + CW, where s = SRCH cycles (1 if R=0, i+1 if matched at i).
  - No match: CW + CW.
  - CORR range failure: CW + s + 1.
- For A=47 and CW=23: R=0 takes 48 cycles; error bit 2 takes 50; error bit 22 takes 70.
- `in_ready`=0 in every state except IDLE. One transaction is in flight at a time, with no buffering.
- Only in DONE, `out_valid`&`out_ready` completes the transaction. IDLE follows the next cycle, so there are no back-to-back accepts.
- `out_ready` is ignored outside DONE.
- `in_valid` asserted while not ready is held off and has no effect.

## Test plan
- Clean word: `ane`=57011 (47·1213) → `n_out`=1213, `err_detected`=0, `err_corrected`=0, and out_valid rises 48 cycles after accept.
- Positive error: `ane`=57015 (R=4) → `n_out`=1213, `err_corrected`=1, pos=2, sign=0, and latency 50. Sweep all 23 single-bit flips of 57011 (e.g. 4251315 → pos 22, sign 0; 57010 → pos 0, sign 1; 24243 → pos 15, sign 1). Every flip must decode to 1213.
- Negative error: `ane`=56979 (R=15) → pos=5, sign=1, `n_out`=1213.
- Range failures:
  - `ane`=3: R=3 matches +2^19, so C is negative → `err_uncorrectable`=1 and `n_out`=0.
  - `ane`=8388607: R=0, and the quotient 178481 ≥ 2^17 → `err_uncorrectable`=1, `err_detected`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0; release → one handshake, then IDLE.
- Reset: assert `rst_n`=0 during DIV → `out_valid` drops immediately and no result appears. A new 57015 after release decodes normally.
